// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_pkg
// Description : Shared widths, register-file geometry and write-back FSM
//               state type for the write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

  localparam int REG_W      = 16;
  localparam int MEM_W      = 32;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  // IDLE accepts a new write-back; WIDE_HI finishes the upper half of a
  // 32-bit load into the second register of the pair.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WIDE_HI = 1'b1
  } wb_state_t;

  // Partner register of a wide load; wraps R7 -> R0 by natural truncation.
  function automatic logic [REG_ADDR_W-1:0] next_idx(input logic [REG_ADDR_W-1:0] idx);
    return idx + REG_ADDR_W'(1);
  endfunction

endpackage : wb_stage_pkg
`default_nettype wire

// File: rtl/wb_stage_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 8 x 16-bit register file, one synchronous write port and two
//               raw (unbypassed) combinational read ports. R0 is ordinary.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
  import wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [REG_W-1:0]      i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr_a,
  input  logic [REG_ADDR_W-1:0] i_raddr_b,
  output logic [REG_W-1:0]      o_rdata_a,
  output logic [REG_W-1:0]      o_rdata_b
);

  logic [REG_W-1:0] r_regs [NUM_REGS];

  // Storage: clear everything on reset, otherwise commit the single write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule : reg_file
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Pipeline write-back stage. Selects ALU or memory data, splits
//               32-bit loads into two consecutive register writes (stalling
//               the MEM/WB buffer for one cycle), exposes the write as a
//               forwarding bus and bypasses it onto the decode read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_WB,
  input  logic                  i_MemToReg,
  input  logic                  i_Wide,
  input  logic [MEM_W-1:0]      i_Mem,
  input  logic [REG_W-1:0]      i_alu,
  input  logic [REG_ADDR_W-1:0] i_Rdst,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_a,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_b,
  output logic [REG_W-1:0]      o_rd_data_a,
  output logic [REG_W-1:0]      o_rd_data_b,
  output logic                  o_stall,
  output logic                  o_fwd_valid,
  output logic [REG_ADDR_W-1:0] o_fwd_Rdst,
  output logic [REG_W-1:0]      o_fwd_data
);

  wb_state_t             r_state;
  logic [REG_W-1:0]      r_hi_data;
  logic [REG_ADDR_W-1:0] r_hi_idx;

  logic                  w_we;
  logic [REG_ADDR_W-1:0] w_waddr;
  logic [REG_W-1:0]      w_wdata;
  logic                  w_stall;
  logic                  w_wide_start;
  logic [REG_W-1:0]      w_raw_a;
  logic [REG_W-1:0]      w_raw_b;

  // Decide the write performed at the coming edge; reset suppresses it.
  always_comb begin
    w_we         = 1'b0;
    w_waddr      = '0;
    w_wdata      = '0;
    w_stall      = 1'b0;
    w_wide_start = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (i_WB) begin
            w_we    = 1'b1;
            w_waddr = i_Rdst;
            if (i_Wide && i_MemToReg) begin
              // Low half now; hold the buffer so the high half goes next cycle.
              w_wdata      = i_Mem[REG_W-1:0];
              w_stall      = 1'b1;
              w_wide_start = 1'b1;
            end else begin
              w_wdata = i_MemToReg ? i_Mem[REG_W-1:0] : i_alu;
            end
          end
        end
        ST_WIDE_HI: begin
          // Buffer inputs still show the held wide load; use latched copies.
          w_we    = 1'b1;
          w_waddr = r_hi_idx;
          w_wdata = r_hi_data;
        end
        default: begin
          w_we = 1'b0;
        end
      endcase
    end
  end

  // FSM and high-half latch for wide loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hi_data <= '0;
      r_hi_idx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wide_start) begin
            r_state   <= ST_WIDE_HI;
            r_hi_data <= i_Mem[MEM_W-1:REG_W];
            r_hi_idx  <= next_idx(i_Rdst);
          end
        end
        ST_WIDE_HI: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  reg_file u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (i_rd_addr_a),
    .i_raddr_b (i_rd_addr_b),
    .o_rdata_a (w_raw_a),
    .o_rdata_b (w_raw_b)
  );

  assign o_stall     = w_stall;
  assign o_fwd_valid = w_we;
  assign o_fwd_Rdst  = w_waddr;
  assign o_fwd_data  = w_wdata;

  // Same-cycle bypass of the pending write; reads are forced to zero in reset.
  assign o_rd_data_a = rst ? '0 :
                       (w_we && (i_rd_addr_a == w_waddr)) ? w_wdata : w_raw_a;
  assign o_rd_data_b = rst ? '0 :
                       (w_we && (i_rd_addr_b == w_waddr)) ? w_wdata : w_raw_b;

endmodule : wb_stage
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 i_WB  in  1  write-back request from MEM/WB buffer.
REQ-004 i_MemToReg  in  1  1 = write memory data, 0 = write ALU result.
REQ-005 i_Wide  in  1  1 with i_MemToReg=1: 32-bit load into register pair Rdst (low half) and Rdst+1 (high half).
REQ-006 i_Mem  in  32  memory data from buffer.
REQ-007 i_alu  in  16  ALU result from buffer.
REQ-008 i_Rdst  in  3  destination register index.
REQ-009 i_rd_addr_a, i_rd_addr_b  in  3 each  decode-stage read addresses.
REQ-010 o_rd_data_a, o_rd_data_b  out  16 each  read data, combinational.
REQ-011 o_stall  out  1  drives MEM/WB buffer enable low (hold) and freezes upstream stages.
REQ-012 o_fwd_valid  out  1  a register write occurs this cycle.
REQ-013 o_fwd_Rdst  out  3  index written this cycle.
REQ-014 o_fwd_data  out  16  value written this cycle.

Function
REQ-015 Contains an 8 x 16-bit register file, one write port, two read ports; R0 is an ordinary register.
REQ-016 FSM states: IDLE, WIDE_HI.
REQ-017 IDLE, i_WB=0: no write; o_fwd_valid=0; o_stall=0.
REQ-018 IDLE, i_WB=1, not wide (i_Wide=0 or i_MemToReg=0): write data = i_MemToReg ? i_Mem[15:0] : i_alu, to i_Rdst at this edge; stay IDLE.
REQ-019 IDLE, i_WB=1, i_Wide=1, i_MemToReg=1: write i_Mem[15:0] to i_Rdst; latch i_Mem[31:16] and (i_Rdst+1) mod 8; o_stall=1 combinationally this cycle; next state WIDE_HI.
REQ-020 Index wrap: i_Rdst=7 gives high-half destination R0.
REQ-021 WIDE_HI: write latched high half to latched index; o_stall=0; all buffer inputs ignored (they repeat the held wide instruction); next state IDLE.
REQ-022 o_fwd_* reflect the write performed at the coming edge, in both states; o_fwd_Rdst/o_fwd_data = 0 when o_fwd_valid=0.
REQ-023 Read ports bypass: if read address equals the write index of the current cycle with o_fwd_valid=1, return o_fwd_data; otherwise return stored value.
REQ-024 Write latency: value visible in storage one edge after the request cycle; visible on read ports in the same cycle via bypass.
REQ-025 Throughput: one non-wide write per cycle; a wide write takes exactly 2 cycles with exactly one stall cycle.
REQ-026 Back-to-back wide loads: after WIDE_HI returns to IDLE, the next wide request is accepted immediately.

Reset
REQ-027 rst=1 at an edge: all 8 registers <= 0, state <= IDLE, latched high half and index <= 0; no write performed that edge.
REQ-028 While rst=1, o_stall=0, o_fwd_valid=0, and read ports return 0 regardless of other inputs.
REQ-029 rst asserted in WIDE_HI cancels the pending high-half write.

Structure
REQ-030 Shared package holds REG_W=16, MEM_W=32, REG_ADDR_W=3, NUM_REGS=8 and the FSM state type.
REQ-031 Register file is a sub-module reg_file (storage, write port, two raw read ports); bypass, FSM and stall logic live in wb_stage.

Verification
REQ-032 Reset, then read all 8 addresses -> every read returns 0x0000, o_stall=0.
REQ-033 i_WB=1, i_MemToReg=0, i_alu=0x1234, i_Rdst=3, read addr a=3 same cycle -> o_rd_data_a=0x1234 (bypass), o_fwd_valid=1; next cycle R3=0x1234.
REQ-034 i_WB=1, i_Wide=1, i_MemToReg=1, i_Mem=0xBEEF_CAFE, i_Rdst=5 held 2 cycles -> cycle 1 o_stall=1, R5<=0xCAFE; cycle 2 o_stall=0, R6<=0xBEEF; no third write.
REQ-035 Wide load with i_Rdst=7, i_Mem=0x0001_0002 -> R7=0x0002, R0=0x0001.
REQ-036 Wide load to R2, rst asserted in WIDE_HI cycle -> R2 and R3 both 0 afterward, state IDLE, o_stall=0.
REQ-037 i_Wide=1, i_MemToReg=0, i_alu=0x00FF, i_Rdst=1 -> single write R1=0x00FF, o_stall never asserted.
